// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetches the instruction at curr_addr over a req/ack
// handshake, holds it for the control FSM until retirement, then issues a
// one-cycle pc_update carrying the sequential or redirected next PC.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned-fetch trap to TRAP_VECTOR).
module pc_fetch_sequencer #(
  parameter int unsigned             BUS_WIDTH   = 32,
  parameter int unsigned             PC_STEP     = 4,
  parameter logic [BUS_WIDTH-1:0]    TRAP_VECTOR = 'h10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] curr_addr,
  output logic [BUS_WIDTH-1:0] next_addr,
  output logic                 pc_update,
  input  logic                 fetch_go,
  output logic                 imem_req,
  output logic [BUS_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [BUS_WIDTH-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 exec_done,
  input  logic                 redirect,
  input  logic [BUS_WIDTH-1:0] redirect_addr,
  output logic                 busy,
  output logic                 fetch_misalign
);

  // FAULT is only ever entered when MISALIGN_TRAP_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_COMMIT = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                 pc_update_q, pc_update_d;
  logic                 imem_req_q, imem_req_d;
  logic [BUS_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [BUS_WIDTH-1:0] instr_q, instr_d;
  logic [BUS_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 busy_q, busy_d;
  logic                 fetch_misalign_q, fetch_misalign_d;
  logic                 misaligned;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (curr_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d          = state_q;
    next_addr_d      = next_addr_q;
    pc_update_d      = 1'b0;
    imem_req_d       = imem_req_q;
    imem_addr_d      = imem_addr_q;
    instr_d          = instr_q;
    instr_pc_d       = instr_pc_q;
    instr_valid_d    = instr_valid_q;
    fetch_misalign_d = fetch_misalign_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_go) begin
          instr_pc_d = curr_addr;
          if (misaligned) begin
            fetch_misalign_d = 1'b1;
            state_d          = S_FAULT;
          end else begin
            imem_addr_d = curr_addr;
            imem_req_d  = 1'b1;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          next_addr_d   = redirect ? redirect_addr
                                   : instr_pc_q + BUS_WIDTH'(PC_STEP);
          instr_valid_d = 1'b0;
          pc_update_d   = 1'b1;
          state_d       = S_COMMIT;
        end
      end
      S_FAULT: begin
        if (exec_done) begin
          next_addr_d      = redirect ? redirect_addr : TRAP_VECTOR;
          fetch_misalign_d = 1'b0;
          pc_update_d      = 1'b1;
          state_d          = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      next_addr_q      <= '0;
      pc_update_q      <= 1'b0;
      imem_req_q       <= 1'b0;
      imem_addr_q      <= '0;
      instr_q          <= '0;
      instr_pc_q       <= '0;
      instr_valid_q    <= 1'b0;
      busy_q           <= 1'b0;
      fetch_misalign_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      next_addr_q      <= next_addr_d;
      pc_update_q      <= pc_update_d;
      imem_req_q       <= imem_req_d;
      imem_addr_q      <= imem_addr_d;
      instr_q          <= instr_d;
      instr_pc_q       <= instr_pc_d;
      instr_valid_q    <= instr_valid_d;
      busy_q           <= busy_d;
      fetch_misalign_q <= fetch_misalign_d;
    end
  end

  assign next_addr      = next_addr_q;
  assign pc_update      = pc_update_q;
  assign imem_req       = imem_req_q;
  assign imem_addr      = imem_addr_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = instr_valid_q;
  assign busy           = busy_q;
  assign fetch_misalign = fetch_misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: transaction-level expected
// waveforms checked every cycle, plus literal pins on directed scenarios.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] TRAP = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] curr_addr, next_addr, imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc, redirect_addr;
  logic        pc_update, fetch_go, imem_req, imem_ack, instr_valid;
  logic        exec_done, redirect, busy, fetch_misalign;

  pc_fetch_sequencer #(.BUS_WIDTH(32), .PC_STEP(4), .TRAP_VECTOR(TRAP)) dut (
    .clk(clk), .rst(rst), .curr_addr(curr_addr), .next_addr(next_addr),
    .pc_update(pc_update), .fetch_go(fetch_go), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .exec_done(exec_done), .redirect(redirect), .redirect_addr(redirect_addr),
    .busy(busy), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        upd;
    logic [31:0] nxt;
    logic        busy;
    logic        mis;
    logic        full;   // all data outputs must be exactly zero (post-reset)
  } exp_t;

  exp_t        exp_next, exp_cur;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_next, last_instr, last_ipc;
  int          upd_pulses = 0;

  function automatic exp_t idle_exp(input logic full);
    exp_t e;
    e.req = 1'b0; e.addr = '0; e.valid = 1'b0; e.instr = '0; e.ipc = '0;
    e.upd = 1'b0; e.nxt = '0; e.busy = 1'b0; e.mis = 1'b0; e.full = full;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the expected waveform.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_cur.req});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_cur.valid});
      chk("pc_update", {31'd0, pc_update}, {31'd0, exp_cur.upd});
      chk("busy", {31'd0, busy}, {31'd0, exp_cur.busy});
      chk("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, exp_cur.mis});
      if (exp_cur.req || exp_cur.full) chk("imem_addr", imem_addr, exp_cur.addr);
      if (exp_cur.valid || exp_cur.full) begin
        chk("instr", instr, exp_cur.instr);
        chk("instr_pc", instr_pc, exp_cur.ipc);
      end
      if (exp_cur.upd || exp_cur.full) chk("next_addr", next_addr, exp_cur.nxt);
      if (pc_update) begin
        last_next = next_addr;
        upd_pulses++;
      end
      if (instr_valid) begin
        last_instr = instr;
        last_ipc   = instr_pc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_cur = exp_next;
    chk_en  = 1'b1;
  endtask

  task automatic noise();
    imem_rdata    = $urandom;
    redirect_addr = $urandom;
    redirect      = 1'($urandom);
  endtask

  // One full fetch/retire transaction; expectations come from the transaction rules.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] rdata,
                        input int idle, input int stall, input int hold,
                        input logic redir, input logic [31:0] raddr);
    exp_t e;
    logic misal;
    for (int i = 0; i < idle; i++) begin
      noise();
      fetch_go = 1'b0; imem_ack = 1'($urandom); exec_done = 1'($urandom);
      curr_addr = $urandom;
      exp_next = idle_exp(1'b0);
      step();
    end
    misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misal = (addr[1:0] != 2'b00);
`endif
    noise();
    fetch_go = 1'b1; curr_addr = addr; imem_ack = 1'($urandom); exec_done = 1'($urandom);
    e = idle_exp(1'b0);
    e.busy = 1'b1;
    if (misal) e.mis = 1'b1;
    else begin
      e.req = 1'b1; e.addr = addr;
    end
    exp_next = e;
    step();
    if (!misal) begin
      for (int i = 0; i < stall; i++) begin
        noise();
        fetch_go = 1'($urandom); curr_addr = $urandom; imem_ack = 1'b0;
        exec_done = 1'($urandom);
        exp_next = e;
        step();
      end
      noise();
      imem_ack = 1'b1; imem_rdata = rdata; exec_done = 1'($urandom);
      fetch_go = 1'($urandom); curr_addr = $urandom;
      e.req = 1'b0; e.valid = 1'b1; e.instr = rdata; e.ipc = addr;
      exp_next = e;
      step();
    end
    for (int i = 0; i < hold; i++) begin
      noise();
      exec_done = 1'b0; imem_ack = 1'($urandom); fetch_go = 1'($urandom);
      curr_addr = $urandom;
      exp_next = e;
      step();
    end
    noise();
    exec_done = 1'b1; redirect = redir; redirect_addr = raddr;
    imem_ack = 1'($urandom); fetch_go = 1'($urandom);
    e.valid = 1'b0; e.mis = 1'b0; e.req = 1'b0; e.upd = 1'b1;
    e.nxt = redir ? raddr : (misal ? TRAP : addr + 32'd4);
    exp_next = e;
    step();
    // COMMIT: a fetch_go here must be ignored.
    noise();
    exec_done = 1'($urandom); imem_ack = 1'($urandom); fetch_go = 1'b1;
    curr_addr = $urandom;
    exp_next = idle_exp(1'b0);
    step();
    fetch_go = 1'b0; exec_done = 1'b0; imem_ack = 1'b0;
  endtask

  initial begin
    int p0;
    rst = 1'b1; fetch_go = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    redirect = 1'b0; redirect_addr = '0; curr_addr = '0; imem_rdata = '0;
    last_next = 32'hDEAD_BEEF; last_instr = '0; last_ipc = '0;
    exp_next = idle_exp(1'b1);
    step();
    step();
    rst = 1'b0;
    exp_next = idle_exp(1'b1);
    step();

    // Basic fetch, zero wait states, sequential retire.
    last_next = 32'hDEAD_BEEF;
    p0 = upd_pulses;
    do_txn(32'h100, 32'h0050_0093, 1, 0, 2, 1'b0, 32'h0);
    chk("t1_instr", last_instr, 32'h0050_0093);
    chk("t1_instr_pc", last_ipc, 32'h100);
    chk("t1_next", last_next, 32'h104);
    chk("t1_pulses", 32'(upd_pulses - p0), 32'd1);

    // Five-cycle memory stall.
    do_txn(32'h200, 32'h1234_5678, 0, 5, 1, 1'b0, 32'h0);
    chk("t2_next", last_next, 32'h204);

    // Redirect on retire.
    last_next = 32'hDEAD_BEEF;
    do_txn(32'h300, 32'hA5A5_0001, 2, 1, 3, 1'b1, 32'h80);
    chk("t3_next", last_next, 32'h80);

    // Wraparound of the sequential increment.
    last_next = 32'hDEAD_BEEF;
    do_txn(32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 0, 1'b0, 32'h0);
    chk("t4_next", last_next, 32'h0000_0000);

    // Reset while waiting for memory, followed by a late ack.
    noise();
    fetch_go = 1'b1; curr_addr = 32'h400; imem_ack = 1'b0;
    exp_next = idle_exp(1'b0);
    exp_next.req = 1'b1; exp_next.addr = 32'h400; exp_next.busy = 1'b1;
    step();
    fetch_go = 1'b0; rst = 1'b1;
    exp_next = idle_exp(1'b1);
    step();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    p0 = upd_pulses;
    exp_next = idle_exp(1'b1);
    step();
    imem_ack = 1'b0;
    exp_next = idle_exp(1'b1);
    step();
    chk("t5_no_update", 32'(upd_pulses - p0), 32'd0);

`ifdef MISALIGN_TRAP_EN
    last_next = 32'hDEAD_BEEF;
    do_txn(32'h102, 32'h0, 1, 0, 2, 1'b0, 32'h0);
    chk("t6_next", last_next, 32'h10);
`endif

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      do_txn(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 5),
             $urandom_range(0, 4), 1'($urandom), $urandom);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
